min_search_ctrl: RTL and testbench
==================================

// Module: min_search_ctrl
// PURPOSE
//  Controller for the 4-entry "smallest value" display datapath. It takes the four
//  pushbutton requesters PB[3:0] and grants them access to the shared 3-bit switch
//  input y. It writes the granted entry and then runs an iterative minimum search.
//  Finally it publishes the ASCII lines to lcd_driver through a valid/ready handshake.
// PARAMETERS
//  VAL_W        3  entry width; must be <= 3 so each entry renders as one ASCII digit
//  SYNC_STAGES  2  synchroniser depth on PB inputs (>= 2)
// PORTS
//  clk        in   1    system clock; all logic on posedge clk
//  reset      in   1    synchronous, active-high reset
//  pb         in   4    raw pushbuttons, asynchronous; one requester per entry
//  y          in   VAL_W  shared value input (switches)
//  upd_ready  in   1    LCD side accepts the new lines
//  upd_valid  out  1    line1/line2 hold a new, stable result
//  line1      out  128  "a, b, c, d,     " (digit = '0'+entry)
//  line2      out  128  1-based min index digit, then 15 spaces
//  min_idx    out  2    0-based index of the smallest entry
//  busy       out  1    high in every state except IDLE
// BEHAVIOUR
//  Reset:
//   entries=0, pending=0, rr_ptr=0, state=IDLE, upd_valid=0, min_idx=0, busy=0.
//   line1="0, 0, 0, 0,     ", line2="1               ".
//  Input path:
//   Each pb bit is synchronised (SYNC_STAGES flops), then rising-edge detected.
//   An edge sets pending[i]. An edge on an already-pending i merges (no count).
//   Edges are captured in every state, so none are lost while busy.
//  FSM states: IDLE -> GRANT -> SEARCH -> FORMAT -> PUBLISH -> IDLE.
//   IDLE:    if |pending, go to GRANT; otherwise stay.
//   GRANT:   round-robin pick of the first pending index at or after rr_ptr.
//            entry[g] <= y sampled this cycle; pending[g] cleared unless a new edge
//            arrives the same cycle (set wins); rr_ptr <= g+1 mod 4.
//   SEARCH:  exactly 4 cycles, k=0..3.
//            k=0 loads cand=entry0, cidx=0.
//            Each later k: if entry[k] < cand (strict), cand/cidx <= entry[k]/k.
//            Ties therefore resolve to the lowest index.
//   FORMAT:  1 cycle; min_idx <= cidx; rebuild line1 and line2 from entries/cidx.
//   PUBLISH: upd_valid=1. Lines and min_idx stay frozen until upd_valid&&upd_ready.
//            On the handshake: upd_valid<=0, go to IDLE.
//            Entries that are still pending wait until IDLE.
//  Latency:
//   Sync edge visible at cycle E; GRANT at E+1 (if IDLE); SEARCH E+2..E+5;
//   FORMAT E+6; upd_valid=1 from E+7.
//   With upd_ready held high, a full transaction is 7 cycles, IDLE to IDLE.
//  Width and encoding:
//   Digit byte = {5'b0,val}+8'h30; index digit = cidx+8'h31.
//   line1 bytes [127:120],[103:96],[79:72],[55:48] carry a..d.
//   Comma 8'h2C and space 8'h20 are fixed.
//  Reset asserted in any state aborts the transaction and restores all reset values
//  in the next cycle; y and pb are ignored while reset is high.
// STRUCTURE
//  Package min_search_pkg:
//   - state encoding localparams
//   - ASCII constants (ZERO=8'h30, ONE=8'h31, SPACE=8'h20, COMMA=8'h2C)
//   - 128-bit LINE1_RESET / LINE2_RESET templates
//   - NUM_ENTRIES=4
//  Sub-module pb_edge_sync (SYNC_STAGES, WIDTH=4): synchroniser plus rising-edge
//  pulse, instantiated once. The round-robin pick, search and formatting stay in
//  this block.
// TESTING
//  1 Reset, then check outputs -> line1="0, 0, 0, 0,     ", line2="1...", upd_valid=0, busy=0.
//  2 y=5, pulse pb[0]; then y=2, pulse pb[1]; ready=1
//    -> second publish shows line1="5, 2, 0, 0,     ", min_idx=2 (entries c,d=0), line2="3...".
//  3 Load a..d = 4,1,6,1 -> min_idx=1, line2="2..." (tie goes to lowest index).
//  4 Press pb[3:0]=4'b1111 in one cycle with rr_ptr=0
//    -> four transactions granted in order 0,1,2,3; rr_ptr ends at 0.
//  5 Hold upd_ready=0 for 20 cycles after upd_valid and press pb[2] meanwhile
//    -> lines stable, pending[2] retained, serviced after the handshake.
//  6 Assert reset during SEARCH -> next cycle all outputs at reset values,
//    with no publish for the aborted request.

Source files
------------

// File: rtl/min_search_ctrl_pkg.sv
// Shared types and constants for the smallest-value display controller.
// Covers the FSM state type, the ASCII bytes, the line templates and the round-robin helper.
package min_search_pkg;

  localparam int unsigned NUM_ENTRIES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SEARCH,
    S_FORMAT,
    S_PUBLISH
  } state_t;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] ONE   = 8'h31;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] COMMA = 8'h2C;

  localparam logic [127:0] LINE1_RESET = {ZERO, COMMA, SPACE, ZERO, COMMA, SPACE,
                                          ZERO, COMMA, SPACE, ZERO, COMMA, {5{SPACE}}};
  localparam logic [127:0] LINE2_RESET = {ONE, {15{SPACE}}};

  // First requester at or after ptr, wrapping; returns ptr when nothing is requesting.
  function automatic logic [1:0] rr_pick(input logic [NUM_ENTRIES-1:0] req,
                                         input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/min_search_ctrl_pb_edge_sync.sv
// Multi-flop synchroniser for asynchronous pushbuttons followed by a
// one-cycle rising-edge pulse per bit.
module pb_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/min_search_ctrl.sv
// Grants pushbutton requesters the shared switch input, stores the value, finds
// the smallest of four entries and publishes two ASCII LCD lines via valid/ready.
module min_search_ctrl
  import min_search_pkg::*;
#(
  parameter int unsigned VAL_W       = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       pb,
  input  logic [VAL_W-1:0] y,
  input  logic             upd_ready,
  output logic             upd_valid,
  output logic [127:0]     line1,
  output logic [127:0]     line2,
  output logic [1:0]       min_idx,
  output logic             busy
);

  state_t                   state;
  logic [VAL_W-1:0]         entry [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]   pending;
  logic [NUM_ENTRIES-1:0]   pb_rise;
  logic [1:0]               rr_ptr;
  logic [1:0]               grant;
  logic [1:0]               k;
  logic [VAL_W-1:0]         cand;
  logic [1:0]               cidx;

  pb_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .WIDTH      (NUM_ENTRIES)
  ) u_pb_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(pb),
    .rise    (pb_rise)
  );

  assign grant = rr_pick(pending, rr_ptr);

  function automatic logic [7:0] digit(input logic [VAL_W-1:0] v);
    return 8'(v) + ZERO;
  endfunction

  function automatic logic [7:0] idx_digit(input logic [1:0] i);
    return 8'(i) + ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) entry[i] <= '0;
      pending   <= '0;
      rr_ptr    <= '0;
      k         <= '0;
      cand      <= '0;
      cidx      <= '0;
      upd_valid <= 1'b0;
      min_idx   <= '0;
      busy      <= 1'b0;
      line1     <= LINE1_RESET;
      line2     <= LINE2_RESET;
    end else begin
      pending <= pending | pb_rise;
      case (state)
        S_IDLE: begin
          // Fresh edges count too, so a request reaches GRANT one cycle after its edge.
          if (|pending || |pb_rise) begin
            state <= S_GRANT;
            busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          entry[grant] <= y;
          pending      <= (pending & ~(4'b0001 << grant)) | pb_rise;
          rr_ptr       <= grant + 2'd1;
          k            <= '0;
          state        <= S_SEARCH;
        end
        S_SEARCH: begin
          if (k == 2'd0) begin
            cand <= entry[0];
            cidx <= 2'd0;
          end else if (entry[k] < cand) begin
            cand <= entry[k];
            cidx <= k;
          end
          k <= k + 2'd1;
          if (k == 2'd3) state <= S_FORMAT;
        end
        S_FORMAT: begin
          min_idx   <= cidx;
          line1     <= {digit(entry[0]), COMMA, SPACE, digit(entry[1]), COMMA, SPACE,
                        digit(entry[2]), COMMA, SPACE, digit(entry[3]), COMMA, {5{SPACE}}};
          line2     <= {idx_digit(cidx), {15{SPACE}}};
          upd_valid <= 1'b1;
          state     <= S_PUBLISH;
        end
        S_PUBLISH: begin
          if (upd_ready) begin
            upd_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_min_search_ctrl.sv
// Scoreboard bench for min_search_ctrl: a transaction-level model predicts every
// published result; a monitor compares each presented result against the queue.
module tb_min_search_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   pb;
  logic [2:0]   y;
  logic         upd_ready;
  logic         upd_valid;
  logic [127:0] line1;
  logic [127:0] line2;
  logic [1:0]   min_idx;
  logic         busy;

  always #5 clk = ~clk;

  min_search_ctrl #(.VAL_W(3), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .pb       (pb),
    .y        (y),
    .upd_ready(upd_ready),
    .upd_valid(upd_valid),
    .line1    (line1),
    .line2    (line2),
    .min_idx  (min_idx),
    .busy     (busy)
  );

  typedef struct packed {
    logic [127:0] l1;
    logic [127:0] l2;
    logic [1:0]   idx;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_entry[4];
  bit          m_pend[4];
  int unsigned m_rr;
  bit          ready_rand  = 1'b0;
  logic        ready_force = 1'b1;

  localparam logic [127:0] L1_ZERO = 128'h302C_2030_2C20_302C_2030_2C20_2020_2020;
  localparam logic [127:0] L2_ONE  = 128'h3120_2020_2020_2020_2020_2020_2020_2020;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_entry[i] = 0;
      m_pend[i]  = 1'b0;
    end
    m_rr = 0;
  endtask

  function automatic logic [127:0] model_line1();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[127-24*i -: 24] = {8'(8'h30 + m_entry[i]), 8'h2C, 8'h20};
    r[31:0] = 32'h2020_2020;
    return r;
  endfunction

  // Serve every pending requester in round-robin order, all sampling value val.
  task automatic model_drain(input logic [2:0] val);
    while (m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3]) begin
      int unsigned g;
      int unsigned mi;
      exp_t        e;
      g = m_rr;
      while (!m_pend[g]) g = (g + 1) % 4;
      m_entry[g] = val;
      m_pend[g]  = 1'b0;
      m_rr       = (g + 1) % 4;
      mi = 0;
      for (int unsigned i = 1; i < 4; i++) if (m_entry[i] < m_entry[mi]) mi = i;
      e.l1  = model_line1();
      e.l2  = {8'(8'h31 + mi), {15{8'h20}}};
      e.idx = 2'(mi);
      sb.push_back(e);
    end
  endtask

  task automatic press(input logic [3:0] mask, input logic [2:0] val);
    y = val;
    for (int i = 0; i < 4; i++) if (mask[i]) m_pend[i] = 1'b1;
    pb = mask;
    repeat (3) @(posedge clk);
    #1 pb = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (sb.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL drain_timeout: outstanding=%0d busy=%0b required outstanding=0 busy=0",
               sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic wait_signal(input string name, input bit want_valid, input int budget);
    int n;
    n = 0;
    while (((want_valid ? upd_valid : busy) !== 1'b1) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if ((want_valid ? upd_valid : busy) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: signal stayed 0, required 1 within %0d cycles", name, budget);
    end
  endtask

  // Ready driver: forced level for directed tests, per-cycle random otherwise.
  initial begin
    upd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 upd_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: every cycle a result is presented it must equal the oldest expectation.
  always @(negedge clk) begin
    if (!reset && upd_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_publish: line1=%h, no result expected", line1);
      end else begin
        check("line1", line1, sb[0].l1);
        check("line2", line2, sb[0].l2);
        check("min_idx", 128'(min_idx), 128'(sb[0].idx));
        check("busy_in_publish", 128'(busy), 128'd1);
        if (upd_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] v;
    reset = 1'b1;
    pb    = '0;
    y     = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_line1", line1, L1_ZERO);
    check("rst_line2", line2, L2_ONE);
    check("rst_upd_valid", 128'(upd_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_min_idx", 128'(min_idx), 128'd0);
    @(posedge clk);
    #1;

    // Two single writes: 5 into a, then 2 into b.
    ready_force = 1'b1;
    press(4'b0001, 3'd5); model_drain(3'd5); wait_idle(100);
    press(4'b0010, 3'd2); model_drain(3'd2); wait_idle(100);

    // Load 4,1,6,1: duplicate minimum resolves to the lower index.
    press(4'b0001, 3'd4); model_drain(3'd4); wait_idle(100);
    press(4'b0010, 3'd1); model_drain(3'd1); wait_idle(100);
    press(4'b0100, 3'd6); model_drain(3'd6); wait_idle(100);
    press(4'b1000, 3'd1); model_drain(3'd1); wait_idle(100);

    // All four buttons at once: served in order 0,1,2,3 from rr_ptr=0.
    press(4'b1111, 3'd3); model_drain(3'd3); wait_idle(200);

    // Stalled consumer with a new request arriving during the stall.
    ready_force = 1'b0;
    v = 3'd2;
    press(4'b0001, v); model_drain(v);
    wait_signal("publish_seen", 1'b1, 50);
    press(4'b0100, v); model_drain(v);
    repeat (14) @(posedge clk);
    #1 ready_force = 1'b1;
    wait_idle(200);

    // Randomised batches with a randomly toggling consumer.
    ready_rand = 1'b1;
    for (int t = 0; t < 20; t++) begin
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      v    = 3'($urandom_range(0, 7));
      press(mask, v);
      model_drain(v);
      wait_idle(400);
    end
    ready_rand  = 1'b0;
    ready_force = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a search aborts the request without a publish.
    y  = 3'd7;
    pb = 4'b0001;
    wait_signal("busy_seen", 1'b0, 20);
    pb = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_line1", line1, L1_ZERO);
    check("abort_line2", line2, L2_ONE);
    check("abort_upd_valid", 128'(upd_valid), 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_min_idx", 128'(min_idx), 128'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;

    // Entries start from zero again after the abort.
    press(4'b1000, 3'd1); model_drain(3'd1); wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
